// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Optional feature macro used by the fetch controller: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  // Instruction presented downstream when no valid fetch is available (addi x0,x0,0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Instruction width in bytes; the PC advances by this amount per fetch.
  localparam logic [63:0] INSTR_BYTES = 64'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Clears the two low address bits so a target always lands on a word boundary.
  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding fetched {pc, instr} pairs between the instruction
// memory and the IF/ID register. A flush empties it and overrides push/pop.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);

  fetch_entry_t mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   cnt;
  logic [1:0]   cnt_next;
  logic         do_push;
  logic         do_pop;

  // Accept decisions: a same-cycle pop frees the slot a push needs.
  always_comb begin
    do_pop   = pop & (cnt != 2'd0) & ~flush;
    do_push  = push & ((cnt != 2'd2) | do_pop) & ~flush;
    cnt_next = cnt;
    if (flush) begin
      cnt_next = 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   cnt_next = cnt + 2'd1;
        2'b01:   cnt_next = cnt - 2'd1;
        default: cnt_next = cnt;
      endcase
    end
  end

  // Entry storage; only the pointers and count need a reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt_next;
    end
  end

  // Status and head view.
  always_comb begin
    head  = mem[rd_ptr];
    full  = (cnt == 2'd2);
    empty = (cnt == 2'd0);
    count = cnt;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: owns the PC, addresses the instruction memory, queues
// returned words with their PC, and handles stalls, EX-stage redirects and
// running off the end of the instruction image.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps to
// HALT and raises a sticky misalign flag; otherwise targets are word-aligned).
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_BYTES = 96,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [63:0] Inst_Adress,
  input  logic [31:0] Instruction,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc,
  output logic        halted
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  // Highest byte address at which a whole instruction still fits in the image.
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - INSTR_BYTES;

  logic [63:0]  pc;
  fetch_state_t state;
  logic         halted_q;

  logic         in_range;
  logic         pop;
  logic         push_req;
  logic         advance;
  logic         drain_done;
  logic         trap;
  logic [63:0]  target;

  fetch_entry_t q_in;
  fetch_entry_t q_head;
  logic         q_full;
  logic         q_empty;
  logic [1:0]   q_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic         misalign_q;
`endif

  // Fetch/pop decisions and redirect target shaping.
  always_comb begin
    // Unsigned compare: a PC that wrapped past 2^64 reads as out of range.
    in_range   = (pc <= LAST_PC);
    pop        = ~q_empty & ~stall;
    push_req   = (state == FETCH) & in_range & ~redirect;
    // Room counts a same-cycle pop, so a full queue keeps streaming.
    advance    = push_req & (~q_full | pop);
    // DRAIN never pushes, so the queue empties after this edge when it is
    // already empty or its last entry is leaving now.
    drain_done = (q_count == 2'd0) | ((q_count == 2'd1) & pop);
    q_in.pc    = pc;
    q_in.instr = Instruction;
`ifdef FETCH_MISALIGN_TRAP_EN
    target     = redirect_pc;
    trap       = (redirect_pc[1:0] != 2'b00);
`else
    target     = word_align(redirect_pc);
    trap       = 1'b0;
`endif
  end

  fetch_queue u_queue (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_req),
    .push_data (q_in),
    .pop       (pop),
    .flush     (redirect),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // PC and fetch FSM; redirect overrides every other activity.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      state    <= FETCH;
      halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else if (redirect) begin
      pc <= target;
      if (trap) begin
        state    <= HALT;
        halted_q <= 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_q <= 1'b1;
`endif
      end else begin
        state    <= FETCH;
        halted_q <= 1'b0;
      end
    end else begin
      case (state)
        FETCH: begin
          if (!in_range) begin
            state <= DRAIN;
          end else if (advance) begin
            pc <= pc + INSTR_BYTES;
          end
        end
        DRAIN: begin
          if (drain_done) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end
        end
        HALT: begin
          halted_q <= 1'b1;
        end
        default: begin
          state    <= HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  // Output view of PC, queue head and status.
  always_comb begin
    Inst_Adress = pc;
    if_valid    = ~q_empty;
    if_instr    = q_empty ? NOP_INSTR : q_head.instr;
    if_pc       = q_empty ? 64'h0 : q_head.pc;
    halted      = halted_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    misalign    = misalign_q;
`endif
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a per-cycle vector table for reset,
// streaming, stall and redirect, plus hand sequences for end of image,
// asynchronous reset mid-run and a misaligned redirect.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk;
  logic        reset_n;
  logic [63:0] Inst_Adress;
  logic [31:0] Instruction;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        halted;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int total;
  int bad;

  imem_fetch_ctrl #(
    .IMEM_BYTES (96),
    .RESET_PC   (64'h0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .Inst_Adress (Inst_Adress),
    .Instruction (Instruction),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .halted      (halted)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign    (misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction image: two known words at 0/4, a known word at 0x30,
  // otherwise a pattern that encodes the address.
  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h00:  return 32'h00000B13;
      64'h04:  return 32'h00500513;
      64'h30:  return 32'hFEAB94E3;
      default: return {16'hA5A5, a[15:0]};
    endcase
  endfunction

  always_comb Instruction = imem(Inst_Adress);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_n;
    logic        stl;
    logic        rdr;
    logic [63:0] rpc;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic [63:0] e_addr;
    logic        e_halted;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [63:0] rp,
                              input logic v, input logic [63:0] p, input logic [31:0] ins,
                              input logic [63:0] ad, input logic h);
    vec_t t;
    t.rst_n = r; t.stl = s; t.rdr = d; t.rpc = rp;
    t.e_valid = v; t.e_pc = p; t.e_instr = ins; t.e_addr = ad; t.e_halted = h;
    return t;
  endfunction

  initial begin
    logic [63:0] exp_pc;
    logic [63:0] last_pc;
    bit          done;

    total = 0;
    bad   = 0;
    reset_n = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 64'h0;

    //          rst stl rdr rpc    valid pc     instr          addr   halted
    vecs[0]  = mk(0, 0, 0, 64'h0,  0, 64'h0,  NOP,           64'h0,  0);
    vecs[1]  = mk(1, 0, 0, 64'h0,  1, 64'h0,  32'h00000B13,  64'h4,  0);
    vecs[2]  = mk(1, 0, 0, 64'h0,  1, 64'h4,  32'h00500513,  64'h8,  0);
    vecs[3]  = mk(1, 0, 0, 64'h0,  1, 64'h8,  32'hA5A50008,  64'hC,  0);
    vecs[4]  = mk(1, 1, 0, 64'h0,  1, 64'h8,  32'hA5A50008,  64'h10, 0);
    vecs[5]  = mk(1, 1, 0, 64'h0,  1, 64'h8,  32'hA5A50008,  64'h10, 0);
    vecs[6]  = mk(1, 1, 0, 64'h0,  1, 64'h8,  32'hA5A50008,  64'h10, 0);
    vecs[7]  = mk(1, 0, 0, 64'h0,  1, 64'hC,  32'hA5A5000C,  64'h14, 0);
    vecs[8]  = mk(1, 0, 0, 64'h0,  1, 64'h10, 32'hA5A50010,  64'h18, 0);
    vecs[9]  = mk(1, 1, 0, 64'h0,  1, 64'h10, 32'hA5A50010,  64'h18, 0);
    vecs[10] = mk(1, 1, 0, 64'h0,  1, 64'h10, 32'hA5A50010,  64'h18, 0);
    vecs[11] = mk(1, 1, 1, 64'h30, 0, 64'h0,  NOP,           64'h30, 0);
    vecs[12] = mk(1, 0, 0, 64'h0,  1, 64'h30, 32'hFEAB94E3,  64'h34, 0);
    vecs[13] = mk(1, 0, 0, 64'h0,  1, 64'h34, 32'hA5A50034,  64'h38, 0);

    #2;
    foreach (vecs[i]) begin
      reset_n     = vecs[i].rst_n;
      stall       = vecs[i].stl;
      redirect    = vecs[i].rdr;
      redirect_pc = vecs[i].rpc;
      tick();
      check($sformatf("v%0d_valid", i),  64'(if_valid),  64'(vecs[i].e_valid));
      check($sformatf("v%0d_pc", i),     if_pc,          vecs[i].e_pc);
      check($sformatf("v%0d_instr", i),  64'(if_instr),  64'(vecs[i].e_instr));
      check($sformatf("v%0d_addr", i),   Inst_Adress,    vecs[i].e_addr);
      check($sformatf("v%0d_halted", i), 64'(halted),    64'(vecs[i].e_halted));
    end
    stall = 1'b0;
    redirect = 1'b0;

    // Run to the end of the image: heads must stay in order up to 92.
    exp_pc  = 64'h38;
    last_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    done    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (if_valid) begin
        check("run_order", if_pc, exp_pc);
        last_pc = if_pc;
        exp_pc  = exp_pc + 64'd4;
      end
      if (halted) done = 1'b1;
    end
    check("halt_reached", 64'(done), 64'd1);
    check("last_pc", last_pc, 64'd92);
    check("halt_valid", 64'(if_valid), 64'd0);
    check("halt_addr", Inst_Adress, 64'd96);
    tick();
    tick();
    check("halt_hold", 64'(halted), 64'd1);
    check("halt_addr_hold", Inst_Adress, 64'd96);
    check("halt_nop", 64'(if_instr), 64'(NOP));

    // Redirect out of HALT back to the start of the image.
    redirect = 1'b1;
    redirect_pc = 64'h0;
    tick();
    redirect = 1'b0;
    check("rst0_valid", 64'(if_valid), 64'd0);
    check("rst0_halted", 64'(halted), 64'd0);
    tick();
    check("rst0_pc", if_pc, 64'h0);
    check("rst0_instr", 64'(if_instr), 64'h00000B13);

    // Stream to head 32 / PC 36, then one stall fills the queue with PC at 40.
    for (int c = 0; c < 8; c++) tick();
    check("pre_head", if_pc, 64'd32);
    stall = 1'b1;
    tick();
    check("pre_addr", Inst_Adress, 64'd40);
    check("pre_head_held", if_pc, 64'd32);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_valid", 64'(if_valid), 64'd0);
    check("async_pc", if_pc, 64'h0);
    check("async_instr", 64'(if_instr), 64'(NOP));
    check("async_addr", Inst_Adress, 64'h0);
    check("async_halted", 64'(halted), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    stall = 1'b0;
    tick();
    check("post_rst_valid", 64'(if_valid), 64'd1);
    check("post_rst_pc", if_pc, 64'h0);

    // Misaligned redirect target.
    redirect = 1'b1;
    redirect_pc = 64'h22;
    tick();
    redirect = 1'b0;
    check("mis_flush", 64'(if_valid), 64'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_flag", 64'(misalign), 64'd1);
    check("mis_halted", 64'(halted), 64'd1);
    check("mis_addr", Inst_Adress, 64'h22);
    tick();
    check("mis_stay_halted", 64'(halted), 64'd1);
    check("mis_stay_invalid", 64'(if_valid), 64'd0);
    check("mis_sticky", 64'(misalign), 64'd1);
`else
    check("mis_addr", Inst_Adress, 64'h20);
    tick();
    check("mis_valid", 64'(if_valid), 64'd1);
    check("mis_pc", if_pc, 64'h20);
    check("mis_instr", 64'(if_instr), 64'hA5A50020);
    check("mis_halted", 64'(halted), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch controller for the 5-stage pipeline. It owns the program counter, drives the byte address into the instruction memory, and captures the returned word with its PC into a 2-entry fetch queue that feeds the IF/ID register. It honours hazard-unit stalls and EX-stage branch redirects, and it halts cleanly when the PC runs past the end of the instruction image.

## Interface
- `IMEM_BYTES`, 96: size of the instruction image in bytes; must be a multiple of 4.
- `RESET_PC`, 64'h0: PC loaded at reset; word-aligned.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: reset; asynchronous, active-low.
- `Inst_Adress` out 64: byte address to the instruction memory; equals the internal PC register.
- `Instruction` in 32: combinational read data from memory for `Inst_Adress`.
- `stall` in 1: hazard unit holds IF/ID; the queue head is not consumed.
- `redirect` in 1: taken branch or jump resolved in EX.
- `redirect_pc` in 64: target byte address, valid with `redirect`.
- `if_valid` out 1: queue head is valid.
- `if_instr` out 32: queue head instruction; 32'h00000013 (NOP) when `if_valid`=0.
- `if_pc` out 64: PC of the queue head; 0 when `if_valid`=0.
- `halted` out 1: fetch has stopped and the queue is empty.

## Operation
- States: FETCH, DRAIN, HALT. Reset enters FETCH.
- **FETCH:**
  - Each cycle with `PC <= IMEM_BYTES-4` and room in the queue: push {PC, `Instruction`}, then PC <= PC+4.
  - "Room" includes a same-cycle pop, so full + pop + push is legal and keeps the queue full.
- **Queue full, no pop:** PC holds and nothing is pushed.
- **End of image:** `PC > IMEM_BYTES-4` stops pushing and moves the FSM to DRAIN.
- **Pop:** happens when `if_valid & ~stall`; the queue is FIFO-ordered.
- **DRAIN:** no fetch; the queue keeps popping. The FSM moves to HALT on the cycle the queue becomes empty (count==0 after the update).
- **HALT:** `halted`=1, no fetch. PC holds. Only `redirect` leaves HALT.
- **Redirect:**
  - Highest priority, over stall, push and pop.
  - Flushes the queue (count <= 0), sets PC <= `redirect_pc`, and moves the FSM to FETCH from any state.
  - No push happens in the redirect cycle.
- **Arithmetic:** the PC increment is 64-bit unsigned and wraps modulo 2^64. The bounds compare is unsigned, so a wrapped PC is above `IMEM_BYTES-4`.
- **Reset mid-operation:** asynchronously clears all state to reset values regardless of FSM state.

## Timing
- **Reset values:**
  - PC = `Inst_Adress` = `RESET_PC`.
  - FSM = FETCH, queue count = 0.
  - `if_valid`=0, `if_instr`=32'h00000013, `if_pc`=0, `halted`=0.
- **Outputs:** `Inst_Adress` is registered. `if_valid`, `if_instr` and `if_pc` are driven from queue storage; there is no combinational path from `Instruction` to them.
- **Latency:** 1 cycle. The first rising edge after `reset_n` deasserts pushes word 0, and `if_valid`=1 from then on.
- **Redirect latency:**
  - The edge that samples `redirect` sets `if_valid`=0.
  - The next edge pushes the target word.
  - `if_valid` is 1 two edges after the redirect sample.
- **Sustained throughput:** one instruction per cycle with `stall`=0.
- **Stall:** a 1-cycle stall holds the head. With the queue full, PC freezes on the second consecutive stall cycle.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- **Defined:**
  - Adds output `misalign` (out 1, reset 0, sticky until reset).
  - A redirect with `redirect_pc[1:0]`!=0 flushes the queue, sets `misalign`=1 and enters HALT; PC is loaded with the raw target.
- **Undefined:** no `misalign` port. `redirect_pc[1:0]` is forced to 0 and the redirect proceeds normally.

## Structure
- Package `fetch_pkg` holds:
  - `NOP_INSTR` = 32'h00000013.
  - The FSM state enum `fetch_state_t` {FETCH, DRAIN, HALT}.
  - The queue entry struct {pc[63:0], instr[31:0]}.
- Sub-module `fetch_queue`:
  - 2-entry FIFO with push, pop, flush, full/empty, count[1:0].
  - Flush overrides push and pop.
- `imem_fetch_ctrl` holds the PC, the FSM and the redirect/end-of-image logic.

## Test plan
- **Reset then run, stall=0, image bytes 0..7:**
  - Edge 1: `if_valid`=1, `if_pc`=0, `if_instr`=32'h00000B13.
  - Edge 2: `if_pc`=4, `if_instr`=32'h00500513.
- **Stall held 3 cycles from `if_pc`=8:**
  - Head stays at 8, the queue fills, PC freezes at 16.
  - Release: 8, 12, 16 appear on consecutive cycles.
- **Redirect to 0x30 while stalled and full:**
  - Next edge: `if_valid`=0.
  - Following edge: `if_pc`=0x30, `if_instr`=32'hFEAB94E3.
- **Run to end, IMEM_BYTES=96:**
  - Last valid `if_pc`=92, then `halted`=1 once the queue drains.
  - `Inst_Adress` holds 96.
  - Redirect to 0 restarts at `if_pc`=0.
- **Reset asserted mid-run (PC=40, queue 2 entries):**
  - All outputs return to reset values immediately.
  - After release, `if_pc`=0 again.
- **With `FETCH_MISALIGN_TRAP_EN`, redirect to 0x22:**
  - `misalign`=1 and `halted`=1 with no valid output.
  - Without the macro: `if_pc`=0x20.
